demux_frame_capture_1x8: RTL and testbench

- Sequential companion stage to the 1-to-8 demultiplexer.
- Accepts a stream of WIDTH-bit words over a valid/ready handshake and steers each word to one of 8 slot registers using an internal 3-bit slot counter. The counter is the select, and it walks 0..7.
- Emits a one-hot per-slot write strobe and presents the assembled 8-word frame to the downstream consumer. The frame is held until the consumer acknowledges it.

---
 rtl/demux_frame_capture_1x8.sv | 56 +++++
 tb/tb_demux_frame_capture_1x8.sv | 90 +++++++++
 2 files changed

// File: rtl/demux_frame_capture_1x8.sv
// demux_frame_capture_1x8: steers a word stream into 8 slots and holds each frame until acked; DEMUX_FRAME_CNT_EN adds frame_count
module demux_frame_capture_1x8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  input  logic               flush,
  output logic [2:0]         slot,
  output logic [7:0]         ch_wr,
  output logic [8*WIDTH-1:0] out_data,
  output logic               frame_valid,
`ifdef DEMUX_FRAME_CNT_EN
  output logic [15:0]        frame_count,
`endif
  input  logic               frame_ack
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  assign in_ready = (state == FILL) && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      slot        <= 3'd0;
      ch_wr       <= 8'd0;
      out_data    <= '0;
      frame_valid <= 1'b0;
`ifdef DEMUX_FRAME_CNT_EN
      frame_count <= 16'd0;
`endif
    end else begin
      ch_wr <= 8'd0;
      if (flush) begin
        slot        <= 3'd0;
        state       <= FILL;
        frame_valid <= 1'b0;
      end else if (state == FILL && in_valid) begin
        out_data[int'(slot)*WIDTH +: WIDTH] <= in_data;
        ch_wr <= 8'd1 << slot;
        slot  <= slot + 3'd1;
        if (slot == 3'd7) begin
          state       <= HOLD;
          frame_valid <= 1'b1;
`ifdef DEMUX_FRAME_CNT_EN
          frame_count <= frame_count + 16'd1;
`endif
        end
      end else if (state == HOLD && frame_ack) begin
        state       <= FILL;
        frame_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_demux_frame_capture_1x8.sv
// tb_demux_frame_capture_1x8: directed plus random stimulus against a slot-array reference model
module tb_demux_frame_capture_1x8;
  logic        clk = 0;
  logic        rst = 1, in_valid = 0, flush = 0, frame_ack = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, frame_valid;
  logic [2:0]  slot;
  logic [7:0]  ch_wr;
  logic [63:0] out_data;
`ifdef DEMUX_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif
  int n_tests = 0, n_fail = 0;
  int idx = 0, frames = 0;
  bit hold = 0;
  logic [7:0] mem [8];
  logic [7:0] exp_wr = 0;
  demux_frame_capture_1x8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .slot(slot), .ch_wr(ch_wr), .out_data(out_data), .frame_valid(frame_valid),
`ifdef DEMUX_FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .frame_ack(frame_ack)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [63:0] frame_word();
    logic [63:0] w = 0;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = mem[k];
    return w;
  endfunction
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic fl, input logic a);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; flush = fl; frame_ack = a;
    #1 check("in_ready", {63'd0, in_ready}, {63'd0, !r && !hold});
    @(posedge clk);
    exp_wr = 0;
    if (r) begin
      idx = 0; hold = 0; frames = 0;
      for (int k = 0; k < 8; k++) mem[k] = 0;
    end else if (fl) begin
      idx = 0; hold = 0;
    end else if (!hold && v) begin
      mem[idx] = d;
      exp_wr = 8'd1 << idx;
      idx = (idx + 1) % 8;
      if (idx == 0) begin hold = 1; frames = (frames + 1) % 65536; end
    end else if (hold && a) hold = 0;
    #1;
    check("slot", {61'd0, slot}, 64'(idx));
    check("ch_wr", {56'd0, ch_wr}, {56'd0, exp_wr});
    check("out_data", out_data, frame_word());
    check("frame_valid", {63'd0, frame_valid}, {63'd0, hold});
`ifdef DEMUX_FRAME_CNT_EN
    check("frame_count", {48'd0, frame_count}, 64'(frames));
`endif
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 8'h33, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, 8'h10 + 8'(k), 0, 0);
    check("basic_frame", out_data, 64'h1716151413121110);
    for (int k = 0; k < 5; k++) step(0, 1, 8'hEE, 0, 0);
    step(0, 1, 8'hEE, 0, 1);
    check("ack_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 16; k++) step(0, k[0] == 0, 8'h20 + 8'(k), 0, 0);
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 1, 8'hA0 + 8'(k), 0, 0);
    step(0, 1, 8'hFF, 1, 0);
    step(0, 1, 8'h55, 0, 0);
    check("flush_slot0", {56'd0, out_data[7:0]}, 64'h55);
    for (int k = 0; k < 7; k++) step(0, 1, 8'h60 + 8'(k), 0, 0);
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 8'h70 + 8'(k), 0, 0);
    step(1, 1, 8'h99, 0, 0);
    check("reset_out", out_data, 64'd0);
    repeat (1500)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
